// File: rtl/load_ext_pipe.sv
// Load-data extender for the W stage: byte/halfword select, zero/sign extension,
// and a two-entry skid buffer. Define LOAD_EXT_ALIGN_CHECK_EN to flag misaligned LH/LHU/LW.
module load_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_addr,
  input  logic [2:0]        in_op,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LBU = 3'd1,
    OP_LB  = 3'd2,
    OP_LHU = 3'd3,
    OP_LH  = 3'd4
  } op_e;

  logic [OFF_W-1:0]  w_half_addr;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic              w_misalign;
  logic [DATA_W-1:0] w_ext_data;
  logic              w_ext_err;

  logic              w_accept;
  logic              w_pop;

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic              r_main_err;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_skid_err;

  // Halfword lanes are even byte offsets; the odd bit is dropped before indexing.
  assign w_half_addr = in_addr & ~OFF_W'(1);
  assign w_byte      = in_data[{in_addr, 3'b000} +: 8];
  assign w_half      = in_data[{w_half_addr, 3'b000} +: 16];

`ifdef LOAD_EXT_ALIGN_CHECK_EN
  assign w_misalign = (((in_op == OP_LH) || (in_op == OP_LHU)) && in_addr[0])
                    || ((in_op == OP_LW) && (in_addr != '0));
`else
  assign w_misalign = 1'b0;
`endif

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    w_ext_data = '0;
    w_ext_err  = 1'b0;
    case (in_op)
      OP_LW:   w_ext_data = in_data;
      OP_LBU:  w_ext_data = {{(DATA_W-8){1'b0}}, w_byte};
      OP_LB:   w_ext_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      OP_LHU:  w_ext_data = {{(DATA_W-16){1'b0}}, w_half};
      OP_LH:   w_ext_data = {{(DATA_W-16){w_half[15]}}, w_half};
      default: w_ext_err  = 1'b1;
    endcase
    if (w_misalign) begin
      w_ext_data = '0;
      w_ext_err  = 1'b1;
    end
  end

  // Ready comes only from stored state so upstream never sees a combinational loop.
  assign in_ready  = !r_skid_valid;
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = r_main_valid && out_ready;

  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_err   = r_main_err;

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_err   <= 1'b0;
    end else if (flush) begin
      // NOTE: only the valid bits are cleared; stale data is harmless while invalid.
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_pop && r_skid_valid) begin
      r_main_data  <= r_skid_data;
      r_main_err   <= r_skid_err;
      r_skid_valid <= 1'b0;
    end else if (w_accept && (!r_main_valid || w_pop)) begin
      r_main_valid <= 1'b1;
      r_main_data  <= w_ext_data;
      r_main_err   <= w_ext_err;
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_ext_data;
      r_skid_err   <= w_ext_err;
    end else if (w_pop) begin
      r_main_valid <= 1'b0;
    end
  end

endmodule
